branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Sits directly downstream of the ALU comparer.
- Captures the comparer's relation code into a flag register and resolves conditional branch requests from decode against it.
- Produces next-PC and taken indication to the fetch stage over a valid/ready handshake.
- Stalls branch requests whose condition needs a flag that has not been produced yet.

Parameters:
DATA_WIDTH, 8, width of relation code input (matches `DATA_WIDTH)
ADDR_WIDTH, 8, width of PC / branch target

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_cmp_valid  input  1  comparer result valid this cycle
i_relation  input  DATA_WIDTH  relation code: 0x3C less, 0x3D equal, 0x3E greater
i_flag_clr  input  1  invalidate flag register (context switch)
i_br_valid  input  1  branch request valid
o_br_ready  output  1  resolver can accept a request
i_br_cond  input  3  0 never, 1 LT, 2 EQ, 3 GT, 4 LE, 5 GE, 6 NE, 7 always
i_br_pc  input  ADDR_WIDTH  PC of branch instruction
i_br_target  input  ADDR_WIDTH  branch target
o_pc_valid  output  1  resolved result valid
i_pc_ready  input  1  fetch accepts result
o_pc_next  output  ADDR_WIDTH  resolved next PC
o_taken  output  1  branch taken
o_flag_err  output  1  sticky: illegal relation code captured

Behaviour:
- Reset (async, rst_n=0): state IDLE, flag_valid=0, flag=0, o_br_ready=1 after release, o_pc_valid=0, o_pc_next=0, o_taken=0, o_flag_err=0, all latched request fields 0.
- Flag register:
  - i_cmp_valid=1 loads i_relation and sets flag_valid=1.
  - Any code other than 0x3C/0x3D/0x3E sets o_flag_err (sticky until reset); the code is stored, and all flag-dependent conditions evaluate not-taken against it.
  - i_flag_clr=1 clears flag_valid. If i_flag_clr and i_cmp_valid occur in the same cycle, the load wins.
- Condition evaluation (LT/EQ/GT against flag):
  - LE = LT|EQ, GE = GT|EQ, NE = !EQ.
  - cond 0 and 7 never need the flag.
- Flag bypass: the flag used is i_relation when i_cmp_valid=1 this cycle, else the flag register. A flag is available when i_cmp_valid=1 or flag_valid=1.
- FSM:
  - IDLE: o_br_ready=1. On i_br_valid, latch cond/pc/target.
    - If the flag is needed and not available -> WAIT.
    - Otherwise resolve using the bypassed flag and go to OUT; o_pc_valid=1 the next cycle (latency 1).
  - WAIT: o_br_ready=0. On i_cmp_valid, resolve with i_relation -> OUT. i_flag_clr has no effect on a WAIT in progress.
  - OUT: o_pc_valid=1 with o_pc_next/o_taken registered and stable until i_pc_ready=1, then -> IDLE. o_br_ready=0; no back-to-back accept in the OUT cycle (throughput 1 per 2 cycles minimum).
- Next PC: taken ? i_br_target : i_br_pc+1, truncated to ADDR_WIDTH (0xFF+1 -> 0x00 at default).
- i_cmp_valid during OUT or WAIT still updates the flag register.
- o_pc_valid deasserts the cycle after the handshake.
- Reset mid-operation discards any pending request; no output is produced for it.

Test Plan:
- Reset, cmp 0x3C then branch cond=1 pc=0x10 tgt=0x40, i_pc_ready=1 -> 1 cycle later o_pc_valid=1, o_pc_next=0x40, o_taken=1.
- Flag 0x3D, cond=6 (NE) pc=0x20 -> o_pc_next=0x21, o_taken=0; cond=5 (GE) -> o_pc_next=target, o_taken=1.
- After reset, branch cond=2 with no compare -> o_br_ready=0, no o_pc_valid; cmp 0x3D 3 cycles later -> next cycle o_pc_valid=1, o_taken=1. Also: cond=7 with no flag resolves immediately, taken.
- Same-cycle i_cmp_valid=0x3E and branch cond=3 with stale flag 0x3C -> bypass used, o_taken=1. Also: pc=0xFF, not-taken -> o_pc_next=0x00.
- i_pc_ready held 0 for 4 cycles -> o_pc_valid/o_pc_next/o_taken stable, o_br_ready=0; accept on cycle 5, IDLE next.
- Relation 0x55 captured -> o_flag_err=1 sticky; cond=1/2/3/4/5/6 all not-taken. Also: rst_n pulsed while in WAIT -> all outputs at reset values, pending request gone.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Handshake bundle between comparer/decode, the branch resolver and fetch.
interface branch_resolver_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_cmp_valid;
    logic [DATA_WIDTH-1:0] i_relation;
    logic                  i_flag_clr;
    logic                  i_br_valid;
    logic                  o_br_ready;
    logic [2:0]            i_br_cond;
    logic [ADDR_WIDTH-1:0] i_br_pc;
    logic [ADDR_WIDTH-1:0] i_br_target;
    logic                  o_pc_valid;
    logic                  i_pc_ready;
    logic [ADDR_WIDTH-1:0] o_pc_next;
    logic                  o_taken;
    logic                  o_flag_err;

    modport master (
        output i_cmp_valid, i_relation, i_flag_clr,
        output i_br_valid, i_br_cond, i_br_pc, i_br_target, i_pc_ready,
        input  o_br_ready, o_pc_valid, o_pc_next, o_taken, o_flag_err
    );

    modport slave (
        input  i_cmp_valid, i_relation, i_flag_clr,
        input  i_br_valid, i_br_cond, i_br_pc, i_br_target, i_pc_ready,
        output o_br_ready, o_pc_valid, o_pc_next, o_taken, o_flag_err
    );
endinterface

// File: rtl/branch_resolver.sv
// Resolves conditional branches against the latest comparer relation code
// and hands next-PC / taken to fetch over a valid/ready handshake.
module branch_resolver #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    branch_resolver_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic [DATA_WIDTH-1:0] REL_LT = DATA_WIDTH'('h3C);
    localparam logic [DATA_WIDTH-1:0] REL_EQ = DATA_WIDTH'('h3D);
    localparam logic [DATA_WIDTH-1:0] REL_GT = DATA_WIDTH'('h3E);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] flag;
    logic                  flag_valid;
    logic                  flag_err;
    logic [2:0]            cond_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] target_q;
    logic [ADDR_WIDTH-1:0] pc_next_q;
    logic                  taken_q;

    // Illegal codes match none of LT/EQ/GT, so every flag-dependent condition is not-taken.
    function automatic logic cond_taken(input logic [2:0] cond,
                                        input logic [DATA_WIDTH-1:0] rel);
        logic lt, eq, gt, res;
        lt = (rel == REL_LT);
        eq = (rel == REL_EQ);
        gt = (rel == REL_GT);
        case (cond)
            3'd0:    res = 1'b0;
            3'd1:    res = lt;
            3'd2:    res = eq;
            3'd3:    res = gt;
            3'd4:    res = lt | eq;
            3'd5:    res = gt | eq;
            3'd6:    res = lt | gt;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic needs_flag(input logic [2:0] cond);
        return (cond != 3'd0) && (cond != 3'd7);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic taken,
                                                      input logic [ADDR_WIDTH-1:0] pc,
                                                      input logic [ADDR_WIDTH-1:0] target);
        return taken ? target : ADDR_WIDTH'(pc + 1'b1);
    endfunction

    logic                  flag_avail;
    logic [DATA_WIDTH-1:0] flag_use;
    logic                  idle_taken;
    logic                  wait_taken;
    logic                  rel_legal;

    always_comb begin
        flag_avail = bus.i_cmp_valid | flag_valid;
        flag_use   = bus.i_cmp_valid ? bus.i_relation : flag;
        idle_taken = cond_taken(bus.i_br_cond, flag_use);
        wait_taken = cond_taken(cond_q, bus.i_relation);
        rel_legal  = (bus.i_relation == REL_LT) || (bus.i_relation == REL_EQ) ||
                     (bus.i_relation == REL_GT);
    end

    // Flag register: a same-cycle load takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag       <= '0;
            flag_valid <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            if (bus.i_cmp_valid) begin
                flag       <= bus.i_relation;
                flag_valid <= 1'b1;
                if (!rel_legal) flag_err <= 1'b1;
            end else if (bus.i_flag_clr) begin
                flag_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cond_q    <= '0;
            pc_q      <= '0;
            target_q  <= '0;
            pc_next_q <= '0;
            taken_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_br_valid) begin
                        cond_q   <= bus.i_br_cond;
                        pc_q     <= bus.i_br_pc;
                        target_q <= bus.i_br_target;
                        if (needs_flag(bus.i_br_cond) && !flag_avail) begin
                            state <= WAIT;
                        end else begin
                            taken_q   <= idle_taken;
                            pc_next_q <= next_pc(idle_taken, bus.i_br_pc, bus.i_br_target);
                            state     <= OUT;
                        end
                    end
                end
                // A clear arriving while waiting is ignored; only a new compare releases us.
                WAIT: begin
                    if (bus.i_cmp_valid) begin
                        taken_q   <= wait_taken;
                        pc_next_q <= next_pc(wait_taken, pc_q, target_q);
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.i_pc_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_br_ready = (state == IDLE);
    assign bus.o_pc_valid = (state == OUT);
    assign bus.o_pc_next  = pc_next_q;
    assign bus.o_taken    = taken_q;
    assign bus.o_flag_err = flag_err;
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized and directed bench for branch_resolver with a queue-based reference model.
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolver_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();
    branch_resolver #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0] cond;
        logic [7:0] pc;
        logic [7:0] tgt;
    } req_t;

    int n_pass = 0;
    int n_total = 0;

    // Reference state: requests awaiting a flag, results awaiting fetch.
    req_t       m_pend[$];
    bit         m_res[$];
    logic [7:0] m_flag;
    bit         m_fvalid;
    bit         m_err;
    logic [7:0] m_pc_next;
    bit         m_taken;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_taken(input logic [2:0] cond, input logic [7:0] rel);
        int s;
        s = (rel == 8'h3C) ? 0 : (rel == 8'h3D) ? 1 : (rel == 8'h3E) ? 2 : 3;
        case (cond)
            3'd0: return 1'b0;
            3'd1: return s == 0;
            3'd2: return s == 1;
            3'd3: return s == 2;
            3'd4: return s inside {0, 1};
            3'd5: return s inside {1, 2};
            3'd6: return s inside {0, 2};
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_clear();
        m_pend.delete();
        m_res.delete();
        m_flag = 8'h00;
        m_fvalid = 1'b0;
        m_err = 1'b0;
        m_pc_next = 8'h00;
        m_taken = 1'b0;
    endtask

    task automatic resolve(input req_t r, input logic [7:0] rel);
        m_taken = model_taken(r.cond, rel);
        m_pc_next = m_taken ? r.tgt : 8'(r.pc + 8'd1);
        m_res.push_back(1'b1);
    endtask

    task automatic model_step();
        req_t r;
        if (m_res.size() != 0) begin
            if (bus.i_pc_ready) void'(m_res.pop_front());
        end else if (m_pend.size() != 0) begin
            if (bus.i_cmp_valid) begin
                r = m_pend.pop_front();
                resolve(r, bus.i_relation);
            end
        end else if (bus.i_br_valid) begin
            r.cond = bus.i_br_cond;
            r.pc = bus.i_br_pc;
            r.tgt = bus.i_br_target;
            if (r.cond != 3'd0 && r.cond != 3'd7 && !(bus.i_cmp_valid || m_fvalid))
                m_pend.push_back(r);
            else
                resolve(r, bus.i_cmp_valid ? bus.i_relation : m_flag);
        end
        if (bus.i_cmp_valid) begin
            m_flag = bus.i_relation;
            m_fvalid = 1'b1;
            if (!(bus.i_relation inside {8'h3C, 8'h3D, 8'h3E})) m_err = 1'b1;
        end else if (bus.i_flag_clr) begin
            m_fvalid = 1'b0;
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("pc_valid", 32'(bus.o_pc_valid), 32'(m_res.size() != 0));
        check("br_ready", 32'(bus.o_br_ready), 32'(m_res.size() == 0 && m_pend.size() == 0));
        check("flag_err", 32'(bus.o_flag_err), 32'(m_err));
        check("pc_next", 32'(bus.o_pc_next), 32'(m_pc_next));
        check("taken", 32'(bus.o_taken), 32'(m_taken));
    end

    task automatic cycle(input bit cmpv, input logic [7:0] rel, input bit clr, input bit brv,
                         input logic [2:0] cond, input logic [7:0] pc, input logic [7:0] tgt,
                         input bit pcr);
        #1;
        bus.i_cmp_valid = cmpv;
        bus.i_relation = rel;
        bus.i_flag_clr = clr;
        bus.i_br_valid = brv;
        bus.i_br_cond = cond;
        bus.i_br_pc = pc;
        bus.i_br_target = tgt;
        bus.i_pc_ready = pcr;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic idle(input bit pcr);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, pcr);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        bus.i_cmp_valid = 1'b0;
        bus.i_relation = 8'h00;
        bus.i_flag_clr = 1'b0;
        bus.i_br_valid = 1'b0;
        bus.i_br_cond = 3'd0;
        bus.i_br_pc = 8'h00;
        bus.i_br_target = 8'h00;
        bus.i_pc_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        // Pin the model's condition table with hand-computed values.
        check("model_ge_eq", 32'(model_taken(3'd5, 8'h3D)), 32'd1);
        check("model_ne_eq", 32'(model_taken(3'd6, 8'h3D)), 32'd0);
        check("model_le_bad", 32'(model_taken(3'd4, 8'h55)), 32'd0);
        check("model_always_bad", 32'(model_taken(3'd7, 8'h55)), 32'd1);

        do_reset();
        check("rst_ready", 32'(bus.o_br_ready), 32'd1);
        check("rst_pc_valid", 32'(bus.o_pc_valid), 32'd0);
        check("rst_pc_next", 32'(bus.o_pc_next), 32'h00);

        // LT taken
        cycle(1, 8'h3C, 0, 0, 3'd0, 8'h00, 8'h00, 1);
        cycle(0, 8'h00, 0, 1, 3'd1, 8'h10, 8'h40, 1);
        check("lt_valid", 32'(bus.o_pc_valid), 32'd1);
        check("lt_next", 32'(bus.o_pc_next), 32'h40);
        check("lt_taken", 32'(bus.o_taken), 32'd1);
        idle(1);
        check("lt_back_idle", 32'(bus.o_br_ready), 32'd1);

        // NE / GE with EQ flag
        cycle(1, 8'h3D, 0, 0, 3'd0, 8'h00, 8'h00, 1);
        cycle(0, 8'h00, 0, 1, 3'd6, 8'h20, 8'h80, 1);
        check("ne_next", 32'(bus.o_pc_next), 32'h21);
        check("ne_taken", 32'(bus.o_taken), 32'd0);
        idle(1);
        cycle(0, 8'h00, 0, 1, 3'd5, 8'h20, 8'h80, 1);
        check("ge_next", 32'(bus.o_pc_next), 32'h80);
        check("ge_taken", 32'(bus.o_taken), 32'd1);
        idle(1);

        // Stall for a flag that doesn't exist yet
        do_reset();
        cycle(0, 8'h00, 0, 1, 3'd2, 8'h30, 8'h50, 1);
        check("wait_ready", 32'(bus.o_br_ready), 32'd0);
        idle(1);
        idle(1);
        check("wait_no_valid", 32'(bus.o_pc_valid), 32'd0);
        cycle(1, 8'h3D, 0, 0, 3'd0, 8'h00, 8'h00, 1);
        check("wait_valid", 32'(bus.o_pc_valid), 32'd1);
        check("wait_taken", 32'(bus.o_taken), 32'd1);
        check("wait_next", 32'(bus.o_pc_next), 32'h50);
        idle(1);
        do_reset();
        cycle(0, 8'h00, 0, 1, 3'd7, 8'h60, 8'h70, 1);
        check("always_valid", 32'(bus.o_pc_valid), 32'd1);
        check("always_next", 32'(bus.o_pc_next), 32'h70);
        idle(1);

        // Bypass over a stale flag, then PC wrap
        cycle(1, 8'h3C, 0, 0, 3'd0, 8'h00, 8'h00, 1);
        cycle(1, 8'h3E, 0, 1, 3'd3, 8'h11, 8'h99, 1);
        check("bypass_taken", 32'(bus.o_taken), 32'd1);
        check("bypass_next", 32'(bus.o_pc_next), 32'h99);
        idle(1);
        cycle(0, 8'h00, 0, 1, 3'd1, 8'hFF, 8'h12, 1);
        check("wrap_next", 32'(bus.o_pc_next), 32'h00);
        check("wrap_taken", 32'(bus.o_taken), 32'd0);
        idle(1);

        // Fetch back-pressure
        cycle(0, 8'h00, 0, 1, 3'd7, 8'h01, 8'hA5, 0);
        for (int i = 0; i < 4; i++) begin
            idle(0);
            check("hold_valid", 32'(bus.o_pc_valid), 32'd1);
            check("hold_next", 32'(bus.o_pc_next), 32'hA5);
            check("hold_ready", 32'(bus.o_br_ready), 32'd0);
        end
        idle(1);
        check("hold_release", 32'(bus.o_pc_valid), 32'd0);
        check("hold_idle", 32'(bus.o_br_ready), 32'd1);

        // Illegal relation code
        cycle(1, 8'h55, 0, 0, 3'd0, 8'h00, 8'h00, 1);
        check("err_set", 32'(bus.o_flag_err), 32'd1);
        for (int c = 1; c <= 6; c++) begin
            cycle(0, 8'h00, 0, 1, 3'(c), 8'h40, 8'h77, 1);
            check("err_not_taken", 32'(bus.o_taken), 32'd0);
            check("err_next", 32'(bus.o_pc_next), 32'h41);
            idle(1);
        end
        cycle(1, 8'h3C, 0, 0, 3'd0, 8'h00, 8'h00, 1);
        check("err_sticky", 32'(bus.o_flag_err), 32'd1);

        // Reset while waiting discards the request
        cycle(0, 8'h00, 1, 0, 3'd0, 8'h00, 8'h00, 1);
        cycle(0, 8'h00, 0, 1, 3'd2, 8'h33, 8'h44, 1);
        check("pre_rst_wait", 32'(bus.o_br_ready), 32'd0);
        do_reset();
        check("rst_err", 32'(bus.o_flag_err), 32'd0);
        check("rst_ready2", 32'(bus.o_br_ready), 32'd1);
        cycle(1, 8'h3D, 0, 0, 3'd0, 8'h00, 8'h00, 1);
        check("rst_discard", 32'(bus.o_pc_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] rel;
            if ($urandom_range(0, 299) == 0) do_reset();
            case ($urandom_range(0, 49))
                0:       rel = 8'($urandom);
                default: rel = 8'h3C + 8'($urandom_range(0, 2));
            endcase
            cycle($urandom_range(0, 9) < 3, rel, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, 3'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
